bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment display driver. It accepts a binary count and a decimal-point mask on a start pulse and runs an iterative shift-add-3 (double-dabble) conversion. It then presents the packed BCD result on `value[15:0]` and the mask on `dots[3:0]`, so the display shows decimal instead of hex. Outputs update atomically on completion and hold steady during conversion, so the display never shows intermediate digits.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_dabble_step.sv | 28 ++
 rtl/bin_to_bcd_seq.sv | 99 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGITS = 4;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic int unsigned bcd_max(input int digits);
    int unsigned m;
    m = 1;
    for (int i = 0; i < digits; i++) begin
      m = m * 10;
    end
    return m - 1;
  endfunction

  localparam int unsigned BCD_MAX       = bcd_max(BCD_DIGITS);
  localparam logic [15:0] BCD_OVF_VALUE = 16'h9999;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the whole {bcd, bin} register left by one bit.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS+BIN_W-1:0] reg_in,
  output logic [4*DIGITS+BIN_W-1:0] reg_out
);

  localparam int REG_W = 4*DIGITS + BIN_W;

  logic [REG_W-1:0] work;

  // Nibbles are <= 9 here, so the 4-bit add never needs a carry-out.
  always_comb begin
    work = reg_in;
    for (int d = 0; d < DIGITS; d++) begin
      if (work[BIN_W+4*d +: 4] >= 4'd5) begin
        work[BIN_W+4*d +: 4] = work[BIN_W+4*d +: 4] + 4'd3;
      end
    end
    reg_out = {work[REG_W-2:0], 1'b0};
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter feeding the seven-segment driver; outputs
// change only on the done cycle so the display never shows partial digits.
//
//   state | meaning
//   IDLE  | waiting for start; operand and mask captured on accept
//   SHIFT | one add-3/shift iteration per clock, BIN_W clocks total
//   DONE  | result (or all-nines on overflow) loaded into outputs
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     dots,
  output logic                  overflow
);

  localparam int REG_W = 4*DIGITS + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam int unsigned LIMIT = bcd_max(DIGITS);
  localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

  state_t            state_q;
  state_t            state_d;
  logic [REG_W-1:0]  sr_q;
  logic [REG_W-1:0]  sr_step;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_pend_q;
  logic [DIGITS-1:0] dp_q;

  bcd_dabble_step #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_step (
    .reg_in  (sr_q),
    .reg_out (sr_step)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      dp_q       <= '0;
      value      <= '0;
      dots       <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q       <= {{(4*DIGITS){1'b0}}, bin};
            dp_q       <= dp_in;
            ovf_pend_q <= (32'(bin) > LIMIT);
            cnt_q      <= '0;
          end
        end
        SHIFT: begin
          sr_q  <= sr_step;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        DONE: begin
          // Overflowed operands still run the full iteration count so latency stays fixed.
          value    <= ovf_pend_q ? NINES : sr_q[REG_W-1 -: 4*DIGITS];
          dots     <= dp_q;
          overflow <= ovf_pend_q;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq with hand-computed results.
module tb_bin_to_bcd_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin   = '0;
  logic [3:0]  dp_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] value;
  logic [3:0]  dots;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] last_v = 16'h0000;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .dp_in    (dp_in),
    .busy     (busy),
    .done     (done),
    .value    (value),
    .dots     (dots),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done after the accepting edge; optionally pokes start/bin=42 at a given edge.
  task automatic wait_done(input string tag, input logic [15:0] hold_v, input int poke);
    int lat;
    int bad;
    lat = 0;
    bad = 0;
    for (int i = 1; i <= 40; i++) begin
      if (poke != 0 && i == poke) begin
        start = 1'b1;
        bin   = 14'd42;
      end
      tick;
      if (poke != 0 && i == poke) start = 1'b0;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (value !== hold_v || busy !== 1'b1) bad++;
    end
    check({tag, " latency"}, 32'(lat), 32'd15);
    check({tag, " hold/busy during conversion"}, 32'(bad), 32'd0);
  endtask

  task automatic conv(input string tag, input logic [13:0] b, input logic [3:0] dp,
                      input logic [15:0] exp_v, input logic [3:0] exp_d,
                      input logic exp_o, input int poke);
    bin   = b;
    dp_in = dp;
    start = 1'b1;
    tick;
    start = 1'b0;
    check({tag, " busy after accept"}, 32'(busy), 32'd1);
    wait_done(tag, last_v, poke);
    check({tag, " value"}, 32'(value), 32'(exp_v));
    check({tag, " dots"}, 32'(dots), 32'(exp_d));
    check({tag, " overflow"}, 32'(overflow), 32'(exp_o));
    check({tag, " busy in done cycle"}, 32'(busy), 32'd0);
    tick;
    check({tag, " done single pulse"}, 32'(done), 32'd0);
    check({tag, " idle after done"}, 32'(busy), 32'd0);
    last_v = exp_v;
  endtask

  initial begin
    int n_done;

    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    check("reset value", 32'(value), 32'h0);
    check("reset dots", 32'(dots), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);

    conv("1234", 14'd1234, 4'b1000, 16'h1234, 4'b1000, 1'b0, 0);
    conv("zero", 14'd0, 4'b0101, 16'h0000, 4'b0101, 1'b0, 0);
    conv("9999", 14'd9999, 4'b0001, 16'h9999, 4'b0001, 1'b0, 0);
    conv("10000", 14'd10000, 4'b0010, 16'h9999, 4'b0010, 1'b1, 0);
    conv("ignored start", 14'd5678, 4'b0100, 16'h5678, 4'b0100, 1'b0, 3);

    // Start held high: second operand captured on the edge after the done cycle.
    bin   = 14'd1;
    dp_in = 4'b0001;
    start = 1'b1;
    tick;
    check("b2b first busy", 32'(busy), 32'd1);
    wait_done("b2b first", last_v, 0);
    check("b2b first value", 32'(value), 32'h0001);
    check("b2b first dots", 32'(dots), 32'h1);
    bin   = 14'd89;
    dp_in = 4'b0010;
    tick;
    start = 1'b0;
    check("b2b second accepted", 32'(busy), 32'd1);
    check("b2b done cleared", 32'(done), 32'd0);
    wait_done("b2b second", 16'h0001, 0);
    check("b2b second value", 32'(value), 32'h0089);
    check("b2b second dots", 32'(dots), 32'h2);
    tick;
    last_v = 16'h0089;

    conv("16383", 14'd16383, 4'b1111, 16'h9999, 4'b1111, 1'b1, 0);

    // Reset asserted at edge 7 of a conversion aborts it.
    bin   = 14'd3456;
    dp_in = 4'b1010;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 1; i <= 6; i++) tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    check("abort value", 32'(value), 32'h0);
    check("abort dots", 32'(dots), 32'h0);
    check("abort overflow", 32'(overflow), 32'h0);
    check("abort busy", 32'(busy), 32'h0);
    check("abort done", 32'(done), 32'h0);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done === 1'b1) n_done++;
    end
    check("abort no done", 32'(n_done), 32'd0);
    last_v = 16'h0000;

    conv("3456 after abort", 14'd3456, 4'b1010, 16'h3456, 4'b1010, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
